// File: rtl/sys1_io_pkg.sv
// Shared types and constants for the HPS I/O helpers of the sys1 platform.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sys1_io_pkg;

  // Upload engine states: idle, waiting for the core to halt, ready for a
  // read strobe, fetching one byte from the shared RAM port.
  typedef enum logic [1:0] {
    NVU_IDLE    = 2'd0,
    NVU_PAUSING = 2'd1,
    NVU_READY   = 2'd2,
    NVU_FETCH   = 2'd3
  } nvu_state_t;

  // Byte returned for addresses outside the save image or on a RAM timeout.
  localparam logic [7:0] NVU_FILL = 8'hFF;

  // Default ioctl_index for the battery/high-score image.
  localparam int unsigned NVU_INDEX = 4;

  // Width of the per-session byte counter (matches ioctl_addr).
  localparam int unsigned NVU_CNT_W = 25;

endpackage

// File: rtl/nvram_upload.sv
// Serves HPS upload reads of the save RAM: halts the core, fetches each byte over a req/ack port, tracks dirty.
// Latency: ioctl_rd at N -> ram_req from N+1; ram_ack at M -> ioctl_din valid at M+1 (out-of-range: N+1).
// Backpressure: ioctl_wait held high while pausing or fetching (and combinationally on an in-range strobe).
module nvram_upload
  import sys1_io_pkg::*;
#(
  parameter int unsigned AW    = 11,
  parameter int unsigned SIZE  = 2048,
  parameter int unsigned INDEX = NVU_INDEX,
  parameter int unsigned TMO   = 255
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic [24:0]   ioctl_addr,
  input  logic          ioctl_rd,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic          ram_req,
  output logic [AW-1:0] ram_addr,
  input  logic          ram_ack,
  input  logic [7:0]    ram_q,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  output logic          dirty,
  output logic          done
);

  localparam int unsigned          TW       = $clog2(TMO + 1);
  localparam logic [TW-1:0]        TMO_LAST = TW'(TMO - 1);
  localparam logic [7:0]           IDX      = 8'(INDEX);
  localparam logic [NVU_CNT_W-1:0] CNT_MAX  = '1;

  nvu_state_t           state, state_nxt;
  logic                 act_q;
  logic [NVU_CNT_W-1:0] count, count_nxt;
  logic [TW-1:0]        tmo, tmo_nxt;
  logic                 err, err_nxt;
  logic                 pause_nxt;
  logic                 req_nxt;
  logic [AW-1:0]        addr_nxt;
  logic [7:0]           din_nxt;
  logic                 done_nxt;
  logic                 dirty_nxt;

  logic                 active;
  logic                 act_rise;
  logic                 act_fall;
  logic                 rd_in_range;
  logic                 wr_in_range;
  logic                 cnt_full;
  logic [NVU_CNT_W-1:0] cnt_inc;

  // Session qualification and edge/range decode.
  always_comb begin
    active      = ioctl_upload & (ioctl_index == IDX);
    act_rise    = active & ~act_q;
    act_fall    = ~active & act_q;
    rd_in_range = (32'(ioctl_addr) < SIZE);
    wr_in_range = (32'(cpu_addr) < SIZE);
    cnt_full    = (32'(count) >= SIZE);
    // Byte counter saturates rather than wrapping so a huge session still reports complete.
    cnt_inc     = (count == CNT_MAX) ? count : count + NVU_CNT_W'(1);
  end

  // Wait is combinational on the strobe so the HPS sees it in the same cycle as ioctl_rd.
  assign ioctl_wait = (state == NVU_PAUSING) | (state == NVU_FETCH) |
                      (ioctl_rd & (state == NVU_READY) & rd_in_range);

  // Next-state and next-output logic; a falling session overrides everything else.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tmo_nxt   = tmo;
    err_nxt   = err;
    pause_nxt = pause_req;
    req_nxt   = ram_req;
    addr_nxt  = ram_addr;
    din_nxt   = ioctl_din;
    done_nxt  = 1'b0;

    if (act_fall) begin
      // Abandon any outstanding fetch; the RAM arbiter tolerates a dropped request.
      state_nxt = NVU_IDLE;
      pause_nxt = 1'b0;
      req_nxt   = 1'b0;
      done_nxt  = cnt_full & ~err;
    end else begin
      case (state)
        NVU_IDLE: begin
          if (act_rise) begin
            pause_nxt = 1'b1;
            count_nxt = '0;
            err_nxt   = 1'b0;
            state_nxt = NVU_PAUSING;
          end
        end
        NVU_PAUSING: begin
          if (pause_ack) begin
            state_nxt = NVU_READY;
          end
        end
        NVU_READY: begin
          if (ioctl_rd) begin
            if (rd_in_range) begin
              addr_nxt  = ioctl_addr[AW-1:0];
              req_nxt   = 1'b1;
              tmo_nxt   = '0;
              state_nxt = NVU_FETCH;
            end else begin
              // Beyond the image: answer immediately with fill, no RAM access.
              din_nxt   = NVU_FILL;
              count_nxt = cnt_inc;
            end
          end
        end
        NVU_FETCH: begin
          if (ram_ack) begin
            din_nxt   = ram_q;
            req_nxt   = 1'b0;
            count_nxt = cnt_inc;
            state_nxt = NVU_READY;
          end else if (tmo == TMO_LAST) begin
            // RAM never answered: return fill and poison this session so it cannot report done.
            din_nxt   = NVU_FILL;
            req_nxt   = 1'b0;
            err_nxt   = 1'b1;
            state_nxt = NVU_READY;
          end else begin
            tmo_nxt = tmo + TW'(1);
          end
        end
        default: begin
          state_nxt = NVU_IDLE;
        end
      endcase
    end

    // A CPU write in the same cycle as a completed upload keeps the image dirty.
    if (cpu_wr & wr_in_range) begin
      dirty_nxt = 1'b1;
    end else if (done_nxt) begin
      dirty_nxt = 1'b0;
    end else begin
      dirty_nxt = dirty;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state     <= NVU_IDLE;
      act_q     <= 1'b0;
      count     <= '0;
      tmo       <= '0;
      err       <= 1'b0;
      pause_req <= 1'b0;
      ram_req   <= 1'b0;
      ram_addr  <= '0;
      ioctl_din <= '0;
      done      <= 1'b0;
      dirty     <= 1'b0;
    end else begin
      state     <= state_nxt;
      act_q     <= active;
      count     <= count_nxt;
      tmo       <= tmo_nxt;
      err       <= err_nxt;
      pause_req <= pause_nxt;
      ram_req   <= req_nxt;
      ram_addr  <= addr_nxt;
      ioctl_din <= din_nxt;
      done      <= done_nxt;
      dirty     <= dirty_nxt;
    end
  end

endmodule

// File: doc/nvram_upload.md
# nvram_upload

Serves HPS upload (save) requests for the game's battery/high-score RAM. Sits in the emu top level next to hps_io: the opposite direction of the ROM/DIP download path. It pauses the game core, answers each `ioctl_rd` with a byte fetched from a shared RAM port via a req/ack handshake, and stretches `ioctl_wait` while fetching. It also tracks CPU writes so the top level can flag unsaved changes.

## Interface
- `AW`, 11: RAM address width.
- `SIZE`, 2048: bytes in the save image; addresses ≥ SIZE return FILL.
- `INDEX`, 4: ioctl_index value selecting this image.
- `TMO`, 255: max cycles waiting for ram_ack.

- `clk_sys`  in  1  system clock (48 MHz); all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `ioctl_upload`  in  1  HPS upload session active.
- `ioctl_index`  in  8  image selector.
- `ioctl_addr`  in  25  byte address of the current read.
- `ioctl_rd`  in  1  one-cycle read strobe.
- `ioctl_din`  out  8  read data to HPS.
- `ioctl_wait`  out  1  HPS must not sample `ioctl_din` or issue a new `ioctl_rd` while high.
- `pause_req`  out  1  request core CPU halt.
- `pause_ack`  in  1  core halted.
- `ram_req`  out  1  RAM read request, held until ack.
- `ram_addr`  out  AW  RAM address, stable while `ram_req`.
- `ram_ack`  in  1  one-cycle; `ram_q` valid in same cycle.
- `ram_q`  in  8  RAM data.
- `cpu_wr`, `cpu_addr[AW]`  in  CPU write snoop.
- `dirty`  out  1  RAM modified since last complete upload.
- `done`  out  1  one-cycle pulse: complete upload finished.

## Operation
- `active = ioctl_upload & (ioctl_index == INDEX)`; `active` is registered once (`act_q`) for edge detection.
- States: IDLE, PAUSING, READY, FETCH.
- IDLE: on `active & ~act_q`: `pause_req`←1, count←0, →PAUSING.
- PAUSING: `ioctl_wait`=1; on `pause_ack` →READY.
- READY: on `ioctl_rd`: latch addr. If addr < SIZE: `ram_addr`←addr[AW-1:0], `ram_req`←1, tmo←0, →FETCH. Else: `ioctl_din`←FILL (8'hFF), count+1, stay READY.
- FETCH: `ram_req`=1. On `ram_ack`: `ioctl_din`←`ram_q`, `ram_req`←0, count+1, →READY. If tmo reaches TMO without ack: `ioctl_din`←FILL, `ram_req`←0, `err` flag set for the session (no count increment), →READY.
- `ioctl_wait` = (state ∈ {PAUSING, FETCH}) | (`ioctl_rd` & state==READY & addr<SIZE). It is combinational on the rd cycle, so wait is high in the same cycle as the strobe.
- `ioctl_rd` in PAUSING/FETCH/IDLE: ignored, no state or count change.
- Falling `active` in any state: `ram_req`←0, `pause_req`←0, →IDLE. `done` pulses if count ≥ SIZE and no err; on that pulse `dirty`←0.
- `dirty`←1 when `cpu_wr` and `cpu_addr` < SIZE. Set wins over a simultaneous clear.
- count width 25 bits, saturating.

## Timing
- Reset (`reset_n`=0 at an edge): state IDLE; `pause_req`, `ram_req`, `done`, err = 0; `ioctl_din`=0; `ram_addr`=0; count=0; `dirty`=0. `ioctl_wait` evaluates to 0.
- Reset mid-FETCH drops `ram_req` on the next edge. The RAM arbiter tolerates an abandoned request.
- Read latency: `ioctl_rd` at cycle N → `ram_req` high from N+1. With ack at cycle M, `ioctl_din` is valid and `ioctl_wait`=0 at M+1.
- Out-of-range reads: `ioctl_din`=FILL at N+1, `ioctl_wait` never high after N.
- `pause_req` rises 1 cycle after `active` rises and falls 1 cycle after `active` falls.
- `done` rises 1 cycle after `active` falls.

## Structure
- Package `sys1_io_pkg`: state enum `nvu_state_t`, `NVU_FILL` = 8'hFF, default INDEX.
- Single module. The edge detector and timeout counter are inline; no sub-module.

## Test plan
- Session start, `pause_ack` 5 cycles later → `ioctl_wait` high exactly those cycles, READY reached, `pause_req`=1.
- Read addr 0x010, RAM model acks 3 cycles after req with 0x5A → `ram_addr`=0x010, `ioctl_din`=0x5A one cycle after ack, wait low then.
- Read addr 0x900 (SIZE=2048) → no `ram_req`, `ioctl_din`=0xFF next cycle, wait never high after strobe.
- Full 2048-byte upload, then session end with a prior CPU write to 0x7FF → `done` single pulse, `dirty` 1→0; `cpu_wr` on the same cycle as the clear → `dirty` stays 1.
- RAM never acks → after 255 cycles `ioctl_din`=0xFF, wait low, session end gives no `done`, `dirty` unchanged.
- `reset_n` low during FETCH → next cycle `ram_req`=0, `pause_req`=0, state IDLE, `ioctl_din`=0.
